// File: rtl/alu_pkg.sv
// Shared constants and opcode encodings for the 32-bit registered ALU.
package alu_pkg;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_LUI  = 4'b1010,
    OP_NOR  = 4'b1100
  } alu_op_e;
endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter shared by SLL, SRL and SRA.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  i_value,
  input  logic [SHAMT_W-1:0] i_amount,
  input  logic               i_left,
  input  logic               i_arith,
  output logic [DATA_W-1:0]  o_result
);
  always_comb begin
    o_result = '0;
    if (i_left)
      o_result = i_value << i_amount;
    else if (i_arith)
      o_result = DATA_W'($signed(i_value) >>> i_amount);
    else
      o_result = i_value >> i_amount;
  end
endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU with zero flag; the signed-overflow flag is
// built only when ALU_OVERFLOW_EN is defined.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opCode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);
  logic [DATA_W-1:0] r_alu_out;
  logic              r_zero;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_shift;
  logic              w_shift_left;
  logic              w_shift_arith;

  assign w_sum         = A + B;
  assign w_diff        = A - B;
  assign w_shift_left  = (opCode == OP_SLL);
  assign w_shift_arith = (opCode == OP_SRA);

  alu_shifter u_shifter (
    .i_value  (B),
    .i_amount (A[SHAMT_W-1:0]),
    .i_left   (w_shift_left),
    .i_arith  (w_shift_arith),
    .o_result (w_shift)
  );

  always_comb begin
    w_result = '0;
    case (opCode)
      OP_AND:  w_result = A & B;
      OP_OR:   w_result = A | B;
      OP_ADD:  w_result = w_sum;
      OP_SLL:  w_result = w_shift;
      OP_XOR:  w_result = A ^ B;
      OP_SRL:  w_result = w_shift;
      OP_SUB:  w_result = w_diff;
      // Direct signed compare stays correct when A-B would overflow.
      OP_SLT:  w_result = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_result = {{(DATA_W-1){1'b0}}, (A < B)};
      OP_SRA:  w_result = w_shift;
      OP_LUI:  w_result = {B[15:0], 16'h0000};
      OP_NOR:  w_result = ~(A | B);
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_out <= '0;
      r_zero    <= 1'b1;
    end else begin
      r_alu_out <= w_result;
      r_zero    <= (w_result == '0);
    end
  end

  assign ALU_Out = r_alu_out;
  assign zero    = r_zero;

`ifdef ALU_OVERFLOW_EN
  logic r_overflow;
  logic w_overflow;

  always_comb begin
    w_overflow = 1'b0;
    if (opCode == OP_ADD)
      w_overflow = (A[DATA_W-1] == B[DATA_W-1]) && (w_sum[DATA_W-1] != A[DATA_W-1]);
    else if (opCode == OP_SUB)
      w_overflow = (A[DATA_W-1] != B[DATA_W-1]) && (w_diff[DATA_W-1] != A[DATA_W-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_overflow <= 1'b0;
    else        r_overflow <= w_overflow;
  end

  assign overflow = r_overflow;
`endif
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequences and
// a random stream compared against an arithmetic reference model.
module tb_alu;
  logic        clk;
  logic        rst_n;
  logic [3:0]  opCode;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALU_Out;
  logic        zero;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opCode  (opCode),
    .A       (A),
    .B       (B),
    .ALU_Out (ALU_Out),
    .zero    (zero)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zero;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference computed from the operation definitions with wide integer arithmetic.
  function automatic logic [31:0] model_out(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, p2;
    longint          sa, sb;
    int              sh;
    ua = a; ub = b;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    sh = int'(a % 32);
    p2 = 64'd1 << sh;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return 32'((ua + ub) % 64'h1_0000_0000);
      4'd3:  return 32'((ub * p2) % 64'h1_0000_0000);
      4'd4:  return a ^ b;
      4'd5:  return 32'(ub / p2);
      4'd6:  return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd9:  return 32'(ub / p2) | (b[31] ? ~32'(64'hFFFF_FFFF / p2) : 32'd0);
      4'd10: return 32'((ub % 65536) * 65536);
      4'd12: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == 4'd2)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd6) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    opCode = op; A = a; B = b;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0010, 32'd7, 32'hA);

    // Reset held for two edges, then released.
    step;
    check("rst1_out", ALU_Out, 32'd0);
    check("rst1_zero", {31'd0, zero}, 32'd1);
`ifdef ALU_OVERFLOW_EN
    check("rst1_ovf", {31'd0, overflow}, 32'd0);
`endif
    step;
    check("rst2_out", ALU_Out, 32'd0);
    check("rst2_zero", {31'd0, zero}, 32'd1);
    rst_n = 1'b1;
    step;
    check("rel_out", ALU_Out, 32'h11);
    check("rel_zero", {31'd0, zero}, 32'd0);

    // Back-to-back ADD, AND, XOR.
    drive(4'b0000, 32'd7, 32'hA);
    step;
    check("b2b_and", ALU_Out, 32'h2);
    check("b2b_and_zero", {31'd0, zero}, 32'd0);
    drive(4'b0100, 32'hA, 32'hA);
    step;
    check("b2b_xor", ALU_Out, 32'h0);
    check("b2b_xor_zero", {31'd0, zero}, 32'd1);

    vecs.push_back(vec_t'{4'b0110, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0111, 32'd5,        32'd7,        32'h1,        1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1000, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0111, 32'h80000000, 32'd1,        32'h1,        1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0011, 32'h24,       32'd1,        32'h10,       1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1001, 32'd4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0101, 32'd4,        32'h80000000, 32'h08000000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1010, 32'd0,        32'h1234,     32'h12340000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1111, 32'd5,        32'd5,        32'h0,        1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1011, 32'hFF,       32'hFF,       32'h0,        1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b1101, 32'h1,        32'h2,        32'h0,        1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0010, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b1, 1'b0});
    vecs.push_back(vec_t'{4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1});
    vecs.push_back(vec_t'{4'b0001, 32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b1001, 32'hFFFFFFE1, 32'h40000000, 32'h20000000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      step;
      check($sformatf("vec%0d_out", i), ALU_Out, vecs[i].exp_out);
      check($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].exp_zero});
`ifdef ALU_OVERFLOW_EN
      check($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
`endif
    end

    // Random back-to-back stream with a one-cycle reset in the middle.
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b, e;
      logic        in_rst;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: a = a & 32'h8000001F;
        1: b = b & 32'h80000001;
        2: b = a;
        default: ;
      endcase
      in_rst = (i == 150);
      rst_n = !in_rst;
      drive(op, a, b);
      step;
      e = in_rst ? 32'd0 : model_out(op, a, b);
      check($sformatf("rnd%0d_out op=%0d", i, op), ALU_Out, e);
      check($sformatf("rnd%0d_zero", i), {31'd0, zero}, {31'd0, (e == 32'd0)});
`ifdef ALU_OVERFLOW_EN
      check($sformatf("rnd%0d_ovf", i), {31'd0, overflow}, {31'd0, (in_rst ? 1'b0 : model_ovf(op, a, b))});
`endif
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
